// File: rtl/tone_sequencer_if.sv
// Command handshake between tone_sequencer (master) and the motion-logic consumer (slave).
// Carries the confirmed 2-bit tone code with a valid/ready pair.
interface tone_sequencer_if;
   logic [1:0] cmd;
   logic       cmd_valid;
   logic       cmd_ready;

   modport master (output cmd, output cmd_valid, input cmd_ready);
   modport slave  (input cmd, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/tone_sequencer.sv
// Arms WaveCount, waits for it to settle, samples its frequency code and issues confirmed tones.
// Optional macro TONE_SEQUENCER_HOLDOFF_EN: require a silent sample between successive commands.
module tone_sequencer #(
   parameter int unsigned SAMPLE_PERIOD = 1_000_000,
   parameter int unsigned CONFIRM_COUNT = 4,
   parameter int unsigned SETTLE_CYCLES = 2_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       freq,
   output logic             wave_enable,
   output logic             busy,
   tone_sequencer_if.master cmd_if
);

   localparam int unsigned TW = $clog2(SAMPLE_PERIOD) + 1;
   localparam int unsigned RW = $clog2(CONFIRM_COUNT) + 1;
   localparam int unsigned SW = $clog2(SETTLE_CYCLES) + 1;

   localparam logic [TW-1:0] TICK_LAST   = TW'(SAMPLE_PERIOD - 1);
   localparam logic [RW-1:0] RUN_MAX     = RW'(CONFIRM_COUNT);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

`ifdef TONE_SEQUENCER_HOLDOFF_EN
   typedef enum logic [2:0] {StIdle, StSettle, StSample, StIssue, StHoldoff} state_e;
`else
   typedef enum logic [2:0] {StIdle, StSettle, StSample, StIssue} state_e;
`endif

   state_e        state;
   logic [TW-1:0] tick_cnt;
   logic [SW-1:0] settle_cnt;
   logic [RW-1:0] run;
   logic [1:0]    candidate;
   logic          stop_pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= StIdle;
         wave_enable      <= 1'b0;
         busy             <= 1'b0;
         cmd_if.cmd       <= 2'd0;
         cmd_if.cmd_valid <= 1'b0;
         tick_cnt         <= '0;
         settle_cnt       <= '0;
         run              <= '0;
         candidate        <= 2'd0;
         stop_pending     <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (start && !stop) begin
                  state       <= StSettle;
                  wave_enable <= 1'b1;
                  busy        <= 1'b1;
                  settle_cnt  <= '0;
               end
            end

            StSettle: begin
               if (stop) begin
                  state        <= StIdle;
                  wave_enable  <= 1'b0;
                  busy         <= 1'b0;
                  stop_pending <= 1'b0;
               end else if (settle_cnt == SETTLE_LAST) begin
                  state     <= StSample;
                  tick_cnt  <= '0;
                  candidate <= 2'd0;
                  run       <= '0;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end

            StSample: begin
               if (stop) begin
                  state        <= StIdle;
                  wave_enable  <= 1'b0;
                  busy         <= 1'b0;
                  stop_pending <= 1'b0;
               end else if (run == RUN_MAX) begin
                  // run is registered, so the command lands one cycle after the confirming tick
                  state            <= StIssue;
                  cmd_if.cmd       <= candidate;
                  cmd_if.cmd_valid <= 1'b1;
               end else if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  if (freq == 2'd0) begin
                     candidate <= 2'd0;
                     run       <= '0;
                  end else if (freq == candidate) begin
                     if (run != RUN_MAX) run <= run + RW'(1);
                  end else begin
                     candidate <= freq;
                     run       <= RW'(1);
                  end
               end else begin
                  tick_cnt <= tick_cnt + TW'(1);
               end
            end

            StIssue: begin
               if (stop) stop_pending <= 1'b1;
               if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                  cmd_if.cmd_valid <= 1'b0;
                  // a stop arriving on the transfer cycle itself is honoured too
                  if (stop_pending || stop) begin
                     state        <= StIdle;
                     wave_enable  <= 1'b0;
                     busy         <= 1'b0;
                     stop_pending <= 1'b0;
                  end else begin
`ifdef TONE_SEQUENCER_HOLDOFF_EN
                     state    <= StHoldoff;
                     tick_cnt <= '0;
`else
                     state     <= StSample;
                     tick_cnt  <= '0;
                     candidate <= 2'd0;
                     run       <= '0;
`endif
                  end
               end
            end

`ifdef TONE_SEQUENCER_HOLDOFF_EN
            StHoldoff: begin
               if (stop) begin
                  state        <= StIdle;
                  wave_enable  <= 1'b0;
                  busy         <= 1'b0;
                  stop_pending <= 1'b0;
               end else if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  if (freq == 2'd0) begin
                     state     <= StSample;
                     candidate <= 2'd0;
                     run       <= '0;
                  end
               end else begin
                  tick_cnt <= tick_cnt + TW'(1);
               end
            end
`endif

            default: begin
               state       <= StIdle;
               wave_enable <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: stimulus queues expected commands, a monitor checks transfers.
// Expectations follow TONE_SEQUENCER_HOLDOFF_EN when it is defined for the build.
module tb_tone_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       stop;
   logic [1:0] freq;
   logic       wave_enable;
   logic       busy;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   int         n_xfer = 0;

   typedef struct {
      logic [1:0] cmd;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   tone_sequencer_if bus ();

   tone_sequencer #(
      .SAMPLE_PERIOD(10),
      .CONFIRM_COUNT(3),
      .SETTLE_CYCLES(20)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .freq       (freq),
      .wave_enable(wave_enable),
      .busy       (busy),
      .cmd_if     (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transfer monitor: every accepted command must match the head of the scoreboard.
   always @(negedge clk) begin
      if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
         n_xfer++;
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_cmd: got cmd %0d at cycle %0d, required none", bus.cmd, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("xfer_cmd", 32'(bus.cmd), 32'(mon_e.cmd));
            if (mon_e.cyc >= 0) check("xfer_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) step();
   endtask

   task automatic arm(output int t);
      start = 1'b1;
      t     = cyc + 1;
      step();
      start = 1'b0;
   endtask

   task automatic disarm(input string name);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check({name, "_idle_busy"}, 32'(busy), 0);
      check({name, "_idle_wave"}, 32'(wave_enable), 0);
   endtask

   initial begin
      int t;
      int x0;
      int bad_valid;
      int bad_busy;

      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      freq  = 2'd0;
      bus.cmd_ready = 1'b0;

      // 1: reset and arm
      repeat (3) step();
      check("rst_wave", 32'(wave_enable), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_cmd", 32'(bus.cmd), 0);
      check("rst_valid", 32'(bus.cmd_valid), 0);
      reset = 1'b0;
      step();

      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      check("start_stop_busy", 32'(busy), 0);

      // 2: confirmed tone, single-cycle pulse at T+51
      freq = 2'd2;
      bus.cmd_ready = 1'b1;
      arm(t);
      sb.push_back('{2'd2, t + 51});
      check("arm_wave", 32'(wave_enable), 1);
      check("arm_busy", 32'(busy), 1);
      wait_until(t + 50);
      check("pre_valid", 32'(bus.cmd_valid), 0);
      wait_until(t + 52);
      check("pulse_end", 32'(bus.cmd_valid), 0);
      check("tone_sb_empty", sb.size(), 0);
      disarm("tone");

      // 3: unstable tone never confirms
      freq = 2'd1;
      arm(t);
      bad_valid = 0;
      bad_busy  = 0;
      for (int i = 0; i < 200; i++) begin
         if (bus.cmd_valid !== 1'b0) bad_valid++;
         if (busy !== 1'b1) bad_busy++;
         if (i % 10 == 9) freq = (freq == 2'd1) ? 2'd3 : 2'd1;
         step();
      end
      check("unstable_valid_cycles", bad_valid, 0);
      check("unstable_busy_drops", bad_busy, 0);
      disarm("unstable");

      // 4: backpressure holds the command stable
      freq = 2'd3;
      bus.cmd_ready = 1'b0;
      arm(t);
      sb.push_back('{2'd3, t + 66});
      wait_until(t + 51);
      for (int i = 0; i < 15; i++) begin
         check("bp_valid", 32'(bus.cmd_valid), 1);
         check("bp_cmd", 32'(bus.cmd), 3);
         step();
      end
      bus.cmd_ready = 1'b1;
      step();
      check("bp_after_valid", 32'(bus.cmd_valid), 0);
      check("bp_sb_empty", sb.size(), 0);
      disarm("bp");

      // 5: held tone, with or without holdoff
      freq = 2'd1;
      x0 = n_xfer;
      arm(t);
`ifdef TONE_SEQUENCER_HOLDOFF_EN
      sb.push_back('{2'd1, t + 51});
      wait_until(t + 200);
      check("holdoff_single_cmd", n_xfer - x0, 1);
      freq = 2'd0;
      wait_until(t + 210);
      freq = 2'd1;
      sb.push_back('{2'd1, t + 233});
      wait_until(t + 240);
      check("holdoff_total_cmds", n_xfer - x0, 2);
`else
      for (int k = 0; k < 5; k++) sb.push_back('{2'd1, t + 51 + 32 * k});
      wait_until(t + 200);
      check("reissue_total_cmds", n_xfer - x0, 5);
`endif
      check("held_sb_empty", sb.size(), 0);
      disarm("held");

      // 6: stop during ISSUE completes the handshake first
      freq = 2'd2;
      bus.cmd_ready = 1'b0;
      arm(t);
      wait_until(t + 53);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stopiss_valid_a", 32'(bus.cmd_valid), 1);
      check("stopiss_busy", 32'(busy), 1);
      wait_until(t + 56);
      check("stopiss_valid_b", 32'(bus.cmd_valid), 1);
      wait_until(t + 57);
      sb.push_back('{2'd2, t + 57});
      bus.cmd_ready = 1'b1;
      step();
      check("stopiss_after_valid", 32'(bus.cmd_valid), 0);
      check("stopiss_wave", 32'(wave_enable), 0);
      check("stopiss_busy_end", 32'(busy), 0);
      check("stopiss_sb_empty", sb.size(), 0);

      // mid-operation reset drops cmd_valid without a transfer
      freq = 2'd3;
      bus.cmd_ready = 1'b0;
      arm(t);
      wait_until(t + 52);
      check("midrst_pre_valid", 32'(bus.cmd_valid), 1);
      reset = 1'b1;
      step();
      check("midrst_valid", 32'(bus.cmd_valid), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_wave", 32'(wave_enable), 0);
      reset = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Control block for the microphone tone front end. It enables the `WaveCount` frequency counter, waits for the counter to settle, and samples its 2-bit frequency code at a fixed interval. Once it has seen the same non-zero code on enough consecutive samples, it issues a confirmed tone command on a valid/ready interface to the downstream motion logic. It sits between `WaveCount` and the command consumer, and it is the only driver of `WaveCount.enable`.

## Interface
- `SAMPLE_PERIOD`, default 1_000_000: clock cycles between frequency samples (10 ms at 100 MHz); must be ≥1.
- `CONFIRM_COUNT`, default 4: number of consecutive identical non-zero samples required to confirm a tone; must be ≥1.
- `SETTLE_CYCLES`, default 2_000_000: cycles after `wave_enable` rises before the first sample window starts; must be ≥1.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: arm request, single-cycle; honoured only in IDLE.
- `stop` in 1: disarm request, single-cycle.
- `freq` in 2: code from `WaveCount`: 0 = none, 1 = 500 Hz, 2 = 1 kHz, 3 = 1.5 kHz.
- `cmd_ready` in 1: consumer accepts `cmd`.
- `wave_enable` out 1: drives `WaveCount.enable`.
- `cmd` out 2: confirmed tone code.
- `cmd_valid` out 1: `cmd` is valid.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, SETTLE, SAMPLE, ISSUE, HOLDOFF. HOLDOFF exists only when the configuration macro is defined.
- **Reset:** state = IDLE. `wave_enable`, `cmd`, `cmd_valid`, `busy`, all counters, `candidate`, `run` and `stop_pending` are 0.
- **IDLE:** `wave_enable` = 0.
  - `start`=1 and `stop`=0 → SETTLE.
  - `start` and `stop` high together → stay in IDLE.
- **SETTLE:** `wave_enable` = 1. After SETTLE_CYCLES cycles in this state → SAMPLE. On entry to SAMPLE, tick counter = 0, `candidate` = 0, `run` = 0.
- **SAMPLE:** a tick occurs every SAMPLE_PERIOD cycles spent in SAMPLE. On each tick:
  - `freq`==0 → `candidate`=0, `run`=0.
  - `freq`==`candidate` → `run`+1.
  - Otherwise → `candidate`=`freq`, `run`=1.
  - When `run` reaches CONFIRM_COUNT → ISSUE, with `cmd`=`candidate` and `cmd_valid`=1.
- **ISSUE:** `cmd` and `cmd_valid` are held stable until a cycle where `cmd_valid` && `cmd_ready`. That cycle is the transfer.
  - `cmd_valid` falls on the next edge.
  - The next state is IDLE if `stop_pending` is set, otherwise HOLDOFF (macro defined) or SAMPLE (macro undefined).
  - Re-entry to SAMPLE clears `candidate` and `run` and restarts the tick counter.
- **HOLDOFF:** ticks continue at SAMPLE_PERIOD. The first tick with `freq`==0 → SAMPLE.
- **`stop`:**
  - In SETTLE, SAMPLE or HOLDOFF → IDLE on the next edge; `wave_enable` falls on that edge.
  - In ISSUE → set `stop_pending`. The handshake is never abandoned; the block goes to IDLE after the transfer.
  - `stop_pending` is cleared on entry to IDLE.
- **Ignored inputs:** `start` outside IDLE is ignored. `freq` is ignored outside SAMPLE and HOLDOFF ticks.
- **Counter widths:** `$clog2` of parameter + 1. Counters saturate and never wrap. `run` never exceeds CONFIRM_COUNT.

## Timing
- All outputs are registered.
- `wave_enable` and `busy` rise on the edge that samples `start`.
- The first tick falls SETTLE_CYCLES + SAMPLE_PERIOD cycles after the `start` edge.
- With a constant non-zero `freq`, `cmd_valid` rises on the edge SETTLE_CYCLES + CONFIRM_COUNT×SAMPLE_PERIOD + 1 cycles after the `start` edge.
- With `cmd_ready` held high, `cmd_valid` is a one-cycle pulse.
- A mid-operation `reset` forces the reset values on the next edge, including dropping `cmd_valid` without a transfer.

## Configuration
- Macro: `TONE_SEQUENCER_HOLDOFF_EN`.
- **Defined:** after each transfer the block requires a silent sample (`freq`==0) before it can confirm a new tone. A held tone therefore produces exactly one command.
- **Undefined:** the block returns straight to SAMPLE. A held tone re-issues a command every CONFIRM_COUNT ticks, plus the handshake cycles.

## Test plan
All scenarios use SAMPLE_PERIOD=10, CONFIRM_COUNT=3, SETTLE_CYCLES=20.

1. **Reset and arm:** assert `reset` for 3 cycles → all outputs 0. Pulse `start` → `wave_enable`=1 and `busy`=1 on that edge.
2. **Confirmed tone:** `freq`=2 held, `cmd_ready`=1, pulse `start` at edge T → `cmd_valid`=1 with `cmd`=2 only during cycle T+51.
3. **Unstable tone:** `freq` alternates 1/3 every 10 cycles for 200 cycles → `cmd_valid` stays 0, `busy` stays 1.
4. **Backpressure:** confirm `freq`=3 with `cmd_ready`=0 for 15 cycles → `cmd_valid`=1 and `cmd`=3 stable throughout. Raise `cmd_ready` → exactly one transfer, then `cmd_valid`=0.
5. **Holdoff:** `freq`=1 held for 200 cycles.
   - Macro defined → exactly 1 command. Then `freq`=0 for one tick and back to 1 → a second command 3 ticks later.
   - Macro undefined → a command every 3 ticks.
6. **Stop during ISSUE:** `stop` pulsed while in ISSUE with `cmd_ready`=0 → `cmd_valid` stays 1. Raise `cmd_ready` → transfer, then IDLE next edge with `wave_enable`=0 and `busy`=0.
